// File: rtl/traceback_unit.sv
// Survivor memory and traceback for the radix-4 Viterbi decoder.
// Emits decoded 2-bit symbols in time order. Optional `TRACEBACK_OVF_EN adds sticky overflow detection.
module traceback_unit #(
  parameter int NUM_ST   = 256,
  parameter int ST_W     = 8,
  parameter int TB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_t,
  input  logic [ST_W-1:0] i_fwd_nxt_st [NUM_ST-1:0],
  input  logic [ST_W-1:0] i_sel_node,
  input  logic            i_last,
  output logic            o_busy,
  output logic [1:0]      o_dec_sym,
  output logic            o_dec_valid,
  output logic            o_dec_last,
  output logic            o_ovf
);

  // state   | meaning
  // COLLECT | accept survivor columns into memory at index cnt
  // TRACE   | walk predecessors from the best state, newest column first
  // EMIT    | stream rev[0..n-1], then one idle cycle before re-accepting

  localparam int PTR_W = $clog2(TB_DEPTH);
  localparam int CNT_W = $clog2(TB_DEPTH + 1);

  typedef enum logic [1:0] {COLLECT, TRACE, EMIT} state_t;

  state_t state, state_nxt;

  logic [ST_W-1:0]  mem [TB_DEPTH-1:0][NUM_ST-1:0];
  logic [1:0]       rev [TB_DEPTH-1:0];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_len;
  logic [CNT_W-1:0] e_idx;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] k;
  logic [ST_W-1:0]  cur_st;
  logic             frame_end;
  logic             col_wr;
  logic             trigger;

  assign col_wr  = en_t && (state == COLLECT);
  assign trigger = col_wr && (i_last || (cnt == CNT_W'(TB_DEPTH - 1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (trigger) state_nxt = TRACE;
      TRACE:   if (k == '0) state_nxt = EMIT;
      EMIT:    if (e_idx == n_len) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    o_busy = (state != COLLECT);
  end

  // Storage is deliberately left unreset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (col_wr) begin
      for (int s = 0; s < NUM_ST; s++) begin
        mem[cnt[PTR_W-1:0]][s] <= i_fwd_nxt_st[s];
      end
    end
    if (state == TRACE) rev[k] <= cur_st[1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      n_len       <= '0;
      e_idx       <= '0;
      ptr         <= '0;
      k           <= '0;
      cur_st      <= '0;
      frame_end   <= 1'b0;
      o_dec_sym   <= 2'b00;
      o_dec_valid <= 1'b0;
      o_dec_last  <= 1'b0;
    end else begin
      o_dec_valid <= 1'b0;
      o_dec_last  <= 1'b0;
      case (state)
        COLLECT: begin
          if (col_wr) begin
            cnt <= cnt + CNT_W'(1);
            if (trigger) begin
              n_len     <= cnt + CNT_W'(1);
              cur_st    <= i_sel_node;
              ptr       <= cnt[PTR_W-1:0];
              k         <= cnt[PTR_W-1:0];
              frame_end <= i_last;
            end
          end
        end
        TRACE: begin
          cur_st <= mem[ptr][cur_st];
          ptr    <= ptr - PTR_W'(1);
          k      <= k - PTR_W'(1);
          e_idx  <= '0;
        end
        EMIT: begin
          // e_idx == n_len is the trailing cycle that keeps o_busy high one edge past the last symbol
          if (e_idx != n_len) begin
            o_dec_sym   <= rev[e_idx[PTR_W-1:0]];
            o_dec_valid <= 1'b1;
            o_dec_last  <= frame_end && (e_idx == n_len - CNT_W'(1));
            e_idx       <= e_idx + CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRACEBACK_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                o_ovf <= 1'b0;
    else if (en_t && o_busy) o_ovf <= 1'b1;
  end
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: symbol streams, window timing, busy drop, reset abort.
module tb_traceback_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_t = 1'b0;
  logic [7:0] fwd [255:0];
  logic [7:0] sel_node = 8'h00;
  logic       i_last = 1'b0;
  logic       o_busy;
  logic [1:0] o_dec_sym;
  logic       o_dec_valid;
  logic       o_dec_last;
  logic       o_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e_edge;
  int idle_cyc;
  int q_sym[$];
  int q_last[$];
  int q_cyc[$];

  traceback_unit #(.NUM_ST(256), .ST_W(8), .TB_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en_t(en_t), .i_fwd_nxt_st(fwd),
    .i_sel_node(sel_node), .i_last(i_last), .o_busy(o_busy),
    .o_dec_sym(o_dec_sym), .o_dec_valid(o_dec_valid),
    .o_dec_last(o_dec_last), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_dec_valid) begin
      q_sym.push_back(int'(o_dec_sym));
      q_last.push_back(int'(o_dec_last));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_sym.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic send_col(input logic [7:0] val, input logic [7:0] sel, input logic last);
    for (int s = 0; s < 256; s++) fwd[s] = val;
    en_t = 1'b1;
    sel_node = sel;
    i_last = last;
    @(posedge clk);
    #1;
    e_edge = cyc;
    en_t = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    idle_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        idle_cyc = cyc;
        break;
      end
    end
    if (idle_cyc < 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_stream(input string tag, input int ex[16], input int n, input int last_on_end);
    chk({tag, "_count"}, q_sym.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_sym%0d", tag, i), (i < q_sym.size()) ? q_sym[i] : -1, ex[i]);
      chk($sformatf("%s_last%0d", tag, i), (i < q_last.size()) ? q_last[i] : -1,
          (i == n - 1) ? last_on_end : 0);
    end
    chk({tag, "_first_cyc"}, (q_cyc.size() > 0) ? q_cyc[0] : -1, e_edge + n + 1);
    chk({tag, "_last_cyc"}, (q_cyc.size() > 0) ? q_cyc[q_cyc.size()-1] : -1, e_edge + 2 * n);
    chk({tag, "_busy_fall"}, idle_cyc, e_edge + 2 * n + 1);
  endtask

  int full_exp[16]  = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 1};
  int part_exp[16]  = '{1, 2, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int one_exp[16]   = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int rev_exp[16]   = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 2};

  initial begin
    for (int s = 0; s < 256; s++) fwd[s] = 8'h00;

    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_sym", int'(o_dec_sym), 0);
    chk("rst_valid", int'(o_dec_valid), 0);
    chk("rst_last", int'(o_dec_last), 0);
    chk("rst_ovf", int'(o_ovf), 0);
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_no_valid", q_sym.size(), 0);
    chk("idle_busy", int'(o_busy), 0);

    // full 16-column block
    clear_q();
    for (int c = 0; c < 16; c++) send_col(8'(c), (c == 15) ? 8'h05 : 8'h00, 1'b0);
    chk("full_busy_rise", int'(o_busy), 1);
    wait_idle("full");
    check_stream("full", full_exp, 16, 0);

    // partial frame ending on i_last
    @(posedge clk); #1;
    clear_q();
    for (int c = 0; c < 5; c++) send_col(8'(8'h40 + c), (c == 4) ? 8'hFE : 8'h00, (c == 4));
    wait_idle("part");
    check_stream("part", part_exp, 5, 1);

    // single-column frame
    @(posedge clk); #1;
    clear_q();
    send_col(8'h00, 8'h03, 1'b1);
    wait_idle("one");
    check_stream("one", one_exp, 1, 1);

    // column arriving while busy is dropped
    @(posedge clk); #1;
    clear_q();
    for (int c = 0; c < 5; c++) send_col(8'(8'h40 + c), (c == 4) ? 8'hFE : 8'h00, (c == 4));
    @(posedge clk); @(posedge clk); #1;
    for (int s = 0; s < 256; s++) fwd[s] = 8'hAA;
    sel_node = 8'h01;
    i_last = 1'b1;
    en_t = 1'b1;
    @(posedge clk); #1;
    en_t = 1'b0;
    i_last = 1'b0;
    wait_idle("drop");
    check_stream("drop", part_exp, 5, 1);
`ifdef TRACEBACK_OVF_EN
    chk("drop_ovf", int'(o_ovf), 1);
`else
    chk("drop_ovf", int'(o_ovf), 0);
`endif

    // reset in the middle of EMIT
    @(posedge clk); #1;
    clear_q();
    for (int c = 0; c < 16; c++) send_col(8'(c), (c == 15) ? 8'h05 : 8'h00, 1'b0);
    for (int i = 0; i < 100 && q_sym.size() < 4; i++) begin
      @(negedge clk); #1;
    end
    chk("mid_seen4", q_sym.size(), 4);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", int'(o_busy), 0);
    chk("mid_sym", int'(o_dec_sym), 0);
    chk("mid_valid", int'(o_dec_valid), 0);
    chk("mid_last", int'(o_dec_last), 0);
    chk("mid_ovf", int'(o_ovf), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_no_more", q_sym.size(), 4);

    clear_q();
    for (int c = 0; c < 16; c++) send_col(8'(15 - c), (c == 15) ? 8'h06 : 8'h00, 1'b0);
    wait_idle("post");
    check_stream("post", rev_exp, 16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traceback_unit.md
# traceback_unit

Survivor-memory and traceback stage of the radix-4 Viterbi decoder. It sits directly downstream of the add-compare-select stage and consumes one survivor column per trellis step. Each column holds a 256-entry predecessor array plus the index of the best-metric state. The block stores up to TB_DEPTH columns, traces back from the best state, and emits the decoded 2-bit symbols in forward (time) order.

## Interface
Parameters:
- NUM_ST, 256: trellis states per column.
- ST_W, 8: state index width; must equal log2(NUM_ST).
- TB_DEPTH, 16: maximum number of columns per traceback block.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- en_t  in  1  survivor column valid this cycle.
- i_fwd_nxt_st  in  ST_W x NUM_ST (unpacked [NUM_ST-1:0])  predecessor state for each state.
- i_sel_node  in  ST_W  best-metric state of this column.
- i_last  in  1  this column ends the frame; qualified by en_t.
- o_busy  out  1  traceback or emit in progress; upstream must hold en_t low.
- o_dec_sym  out  2  decoded symbol.
- o_dec_valid  out  1  o_dec_sym valid.
- o_dec_last  out  1  final symbol of a frame; coincides with o_dec_valid.
- o_ovf  out  1  sticky flag: column dropped while busy.

## Operation
- Survivor memory: TB_DEPTH x NUM_ST x ST_W entries. Rev buffer: TB_DEPTH x 2. Column count cnt ranges 0..TB_DEPTH. Block length n is latched at trigger.
- FSM states: COLLECT, TRACE, EMIT.
- COLLECT, en_t=1: write the column at index cnt, then cnt<=cnt+1.
  - Trigger when the written column brings cnt to TB_DEPTH, or when i_last=1.
  - On trigger: n<=cnt+1, cur_st<=i_sel_node, ptr<=cnt, k<=n-1, frame_end<=i_last, state goes to TRACE.
- TRACE, one step per cycle:
  - rev[k]<=cur_st[1:0].
  - cur_st<=mem[ptr][cur_st].
  - ptr<=ptr-1, k<=k-1.
  - After n steps, go to EMIT.
- EMIT, one symbol per cycle, no backpressure:
  - Output rev[0] through rev[n-1] in order.
  - o_dec_last=1 on rev[n-1] only if frame_end=1.
  - After the last symbol: cnt<=0, state goes to COLLECT.
- The decoded symbol for a column is the two LSBs of the state traced at that column. Newest input bits occupy the state LSBs.
- Memory contents are not reset. Only cnt and the FSM are reset.

## Timing
- Reset values:
  - o_busy=0, o_dec_sym=0, o_dec_valid=0, o_dec_last=0, o_ovf=0.
  - FSM=COLLECT, cnt=0.
- Reset asserted mid-TRACE or mid-EMIT aborts immediately. No further o_dec_valid; the partial block is discarded.
- Let the trigger column be written at edge E:
  - o_busy=1 from edge E.
  - TRACE steps occur at edges E+1..E+n.
  - o_dec_valid=1 after edges E+n+1..E+2n (n consecutive cycles).
  - o_dec_valid and o_busy fall at edge E+2n+1.
- en_t is accepted again in the first cycle with o_busy=0.
- en_t=1 while o_busy=1: the column is ignored, and cnt and memory are unchanged.
- i_last with en_t=0 has no effect.
- i_last on the first column (cnt=0) gives n=1: one symbol, with o_dec_last=1.
- i_last on the TB_DEPTH-th column gives n=TB_DEPTH and frame_end=1.
- After a full block without i_last, the frame continues and the next block starts at cnt=0.

## Configuration
- TRACEBACK_OVF_EN defined: o_ovf is set at the edge where en_t=1 and o_busy=1. It stays set until reset.
- Not defined: o_ovf is tied to 0 and no detection logic is built. Dropped columns remain silently ignored.

## Test plan
- Reset, then idle: all outputs 0; en_t=0 for 50 cycles -> o_dec_valid never rises.
- Full block (TB_DEPTH=16): 16 columns where column c maps every state to state c, i_sel_node=0x05 on column 15 -> symbols 01,10,11,00,01,10,11,00,01,10,11,00,01,10,11,01. o_dec_last=0 throughout; o_dec_valid window is 16 cycles starting at edge E+17.
- Partial frame: 5 columns where column c maps every state to state 0x40+c; i_last and i_sel_node=0xFE on column 4 -> symbols 01,10,11,00,10, with o_dec_last=1 on the fifth.
- Single-column frame: en_t and i_last together on the first column with i_sel_node=0x03 -> exactly one symbol 11, with o_dec_last=1, two cycles after the trigger edge.
- Column during busy: en_t pulse 3 cycles after a trigger -> column ignored and symbol stream unchanged. o_ovf=1 with TRACEBACK_OVF_EN defined; o_ovf=0 without it.
- Reset mid-EMIT after 4 symbols -> all outputs 0 next cycle; a following 16-column block decodes correctly.
